// File: rtl/w_writeback_grf.sv
// Writeback stage: decodes the W-stage instruction, commits the result to the
// 32x32 register file, and serves two bypassed D-stage read ports.
module w_writeback_grf #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] w_pc,
    input  logic [31:0] w_instr,
    input  logic [31:0] w_alu_out,
    input  logic [31:0] w_dm_out,
    input  logic [31:0] w_ext,
    input  logic [4:0]  d_rs_addr,
    input  logic [4:0]  d_rt_addr,
    output logic [31:0] d_rs_data,
    output logic [31:0] d_rt_data,
    output logic        w_we,
    output logic [4:0]  w_wa,
    output logic [31:0] w_wd,
    output logic [31:0] retire_cnt
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnSub   = 6'b100010;

    logic [31:0] regs_q [32];
    logic [31:0] retire_cnt_q;
    logic        dec_we;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;

    assign opcode = w_instr[31:26];
    assign funct  = w_instr[5:0];
    assign rt     = w_instr[20:16];
    assign rd     = w_instr[15:11];

    always_comb begin
        dec_we = 1'b0;
        w_wa   = 5'd0;
        w_wd   = 32'd0;
        case (opcode)
            OpRtype: begin
                if (funct == FnAdd || funct == FnSub) begin
                    dec_we = 1'b1;
                    w_wa   = rd;
                    w_wd   = w_alu_out;
                end
            end
            OpOri: begin
                dec_we = 1'b1;
                w_wa   = rt;
                w_wd   = w_alu_out;
            end
            OpLui: begin
                dec_we = 1'b1;
                w_wa   = rt;
                w_wd   = w_ext;
            end
            OpLw: begin
                dec_we = 1'b1;
                w_wa   = rt;
                w_wd   = w_dm_out;
            end
            OpJal: begin
                dec_we = 1'b1;
                w_wa   = 5'd31;
                w_wd   = w_pc + 32'd8;
            end
            default: ;
        endcase
    end

    // $0 is hard-wired: a write to it is neither committed nor bypassed.
    assign w_we = dec_we && (w_wa != 5'd0);

    always_comb begin
        if (d_rs_addr == 5'd0) begin
            d_rs_data = 32'd0;
        end else if (w_we && w_wa == d_rs_addr) begin
            d_rs_data = w_wd;
        end else begin
            d_rs_data = regs_q[d_rs_addr];
        end
    end

    always_comb begin
        if (d_rt_addr == 5'd0) begin
            d_rt_data = 32'd0;
        end else if (w_we && w_wa == d_rt_addr) begin
            d_rt_data = w_wd;
        end else begin
            d_rt_data = regs_q[d_rt_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (w_we) begin
            regs_q[w_wa] <= w_wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= 32'd0;
        end else if (w_instr != 32'd0) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            if (w_pc < PC_RESET) begin
                $display("@%h: pc below reset vector", w_pc);
            end
            $display("@%h: $%d <= %h", w_pc, w_wa, w_wd);
        end
    end
`endif

endmodule

// File: tb/tb_w_writeback_grf.sv
// Directed bench for w_writeback_grf: reset sequence plus a table of
// per-cycle vectors checking decode, bypass, storage and the retire counter.
module tb_w_writeback_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] w_pc, w_instr, w_alu_out, w_dm_out, w_ext;
    logic [4:0]  d_rs_addr, d_rt_addr;
    logic [31:0] d_rs_data, d_rt_data, w_wd, retire_cnt;
    logic        w_we;
    logic [4:0]  w_wa;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    w_writeback_grf #(.PC_RESET(32'h0000_3000)) dut (
        .clk        (clk),
        .reset      (reset),
        .w_pc       (w_pc),
        .w_instr    (w_instr),
        .w_alu_out  (w_alu_out),
        .w_dm_out   (w_dm_out),
        .w_ext      (w_ext),
        .d_rs_addr  (d_rs_addr),
        .d_rt_addr  (d_rt_addr),
        .d_rs_data  (d_rs_data),
        .d_rt_data  (d_rt_data),
        .w_we       (w_we),
        .w_wa       (w_wa),
        .w_wd       (w_wd),
        .retire_cnt (retire_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] dm,
                         input logic [31:0] ext, input logic [4:0] rs, input logic [4:0] rt);
        w_instr   = instr;
        w_pc      = pc;
        w_alu_out = alu;
        w_dm_out  = dm;
        w_ext     = ext;
        d_rs_addr = rs;
        d_rt_addr = rt;
    endtask

    initial begin
        //           instr         pc            alu           dm            ext           rs  rt  we wa  wd            rs_data       rt_data       cnt
        vecs[0]  = '{32'h34051234, 32'h00003000, 32'h00001234, 32'h0,        32'h0,        5,  0,  1, 5,  32'h00001234, 32'h00001234, 32'h0,        1};
        vecs[1]  = '{32'h00000000, 32'h00003004, 32'h0,        32'h0,        32'h0,        5,  5,  0, 0,  32'h0,        32'h00001234, 32'h00001234, 1};
        vecs[2]  = '{32'h8C080000, 32'h00003008, 32'h00000055, 32'hDEADBEEF, 32'h0,        8,  5,  1, 8,  32'hDEADBEEF, 32'hDEADBEEF, 32'h00001234, 2};
        vecs[3]  = '{32'h00004820, 32'h0000300C, 32'h00000007, 32'h11111111, 32'h0,        8,  9,  1, 9,  32'h00000007, 32'hDEADBEEF, 32'h00000007, 3};
        vecs[4]  = '{32'h0C000C01, 32'h00003004, 32'h00000099, 32'h0,        32'h0,        31, 31, 1, 31, 32'h0000300C, 32'h0000300C, 32'h0000300C, 4};
        vecs[5]  = '{32'h00000020, 32'h00003014, 32'h0000FFFF, 32'h0,        32'h0,        0,  0,  0, 0,  32'h0000FFFF, 32'h0,        32'h0,        5};
        vecs[6]  = '{32'h00005022, 32'h00003018, 32'hFFFFFFFE, 32'h0,        32'h0,        10, 9,  1, 10, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000007, 6};
        vecs[7]  = '{32'h3C0B0000, 32'h0000301C, 32'h00000001, 32'h00000002, 32'hABCD0000, 11, 31, 1, 11, 32'hABCD0000, 32'hABCD0000, 32'h0000300C, 7};
        vecs[8]  = '{32'hAC080000, 32'h00003020, 32'h00000099, 32'h0,        32'h0,        8,  5,  0, 0,  32'h0,        32'hDEADBEEF, 32'h00001234, 8};
        vecs[9]  = '{32'h10000003, 32'h00003024, 32'h00000001, 32'h0,        32'h0,        9,  10, 0, 0,  32'h0,        32'h00000007, 32'hFFFFFFFE, 9};
        vecs[10] = '{32'h03E00008, 32'h00003028, 32'h00000002, 32'h0,        32'h0,        31, 11, 0, 0,  32'h0,        32'h0000300C, 32'hABCD0000, 10};
        vecs[11] = '{32'hFC000000, 32'h0000302C, 32'h00000077, 32'h0,        32'h0,        5,  8,  0, 0,  32'h0,        32'h00001234, 32'hDEADBEEF, 11};
        vecs[12] = '{32'h00004824, 32'h00003030, 32'h00000088, 32'h0,        32'h0,        9,  9,  0, 0,  32'h0,        32'h00000007, 32'h00000007, 12};
        vecs[13] = '{32'h34000042, 32'h00003034, 32'h00000042, 32'h0,        32'h0,        0,  0,  0, 0,  32'h00000042, 32'h0,        32'h0,        13};
        vecs[14] = '{32'h00000000, 32'h00003038, 32'h0,        32'h0,        32'h0,        10, 11, 0, 0,  32'h0,        32'hFFFFFFFE, 32'hABCD0000, 13};
        vecs[15] = '{32'h3405CAFE, 32'h0000303C, 32'h0000CAFE, 32'h0,        32'h0,        5,  5,  1, 5,  32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE, 14};
        vecs[16] = '{32'h00000000, 32'h00003040, 32'h0,        32'h0,        32'h0,        5,  0,  0, 0,  32'h0,        32'h0000CAFE, 32'h0,        14};

        // Power-on reset
        reset = 1'b1;
        drive(32'h0, 32'h3000, 32'h0, 32'h0, 32'h0, 5'd7, 5'd31);
        #2;
        chk("por_cnt", retire_cnt, 32'h0);
        chk("por_rs", d_rs_data, 32'h0);
        chk("por_rt", d_rt_data, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        drive(32'h34071111, 32'h3000, 32'h00001111, 32'h0, 32'h0, 5'd7, 5'd0);
        @(posedge clk);
        @(negedge clk);
        drive(32'h0, 32'h3004, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);
        #1;
        chk("pre_rst_store", d_rs_data, 32'h00001111);
        chk("pre_rst_cnt", retire_cnt, 32'h1);

        // Asynchronous reset between edges clears state immediately
        #1;
        reset = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            d_rs_addr = a[4:0];
            d_rt_addr = 5'(31 - a);
            #0.1;
            chk($sformatf("rst_rs_%0d", a), d_rs_data, 32'h0);
            chk($sformatf("rst_rt_%0d", a), d_rt_data, 32'h0);
        end
        chk("rst_cnt", retire_cnt, 32'h0);

        // A write pending across an edge while reset is held is not committed
        @(negedge clk);
        drive(32'h34072222, 32'h3008, 32'h00002222, 32'h0, 32'h0, 5'd7, 5'd7);
        #1;
        chk("rst_decode_wa", {27'd0, w_wa}, 32'd7);
        chk("rst_decode_wd", w_wd, 32'h00002222);
        @(posedge clk);
        @(negedge clk);
        drive(32'h0, 32'h300C, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);
        #1;
        chk("rst_wins_reg", d_rs_data, 32'h0);
        chk("rst_wins_cnt", retire_cnt, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].pc, vecs[i].alu, vecs[i].dm, vecs[i].ext,
                  vecs[i].rs, vecs[i].rt);
            #2;
            chk($sformatf("v%0d_we", i), {31'd0, w_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_wa", i), {27'd0, w_wa}, {27'd0, vecs[i].e_wa});
            chk($sformatf("v%0d_wd", i), w_wd, vecs[i].e_wd);
            chk($sformatf("v%0d_rs", i), d_rs_data, vecs[i].e_rs);
            chk($sformatf("v%0d_rt", i), d_rt_data, vecs[i].e_rt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cnt", i), retire_cnt, vecs[i].e_cnt);
        end

        // Final sweep of stored values with a bubble in W
        @(negedge clk);
        drive(32'h0, 32'h3100, 32'h0, 32'h0, 32'h0, 5'd8, 5'd10);
        #1;
        chk("final_r8", d_rs_data, 32'hDEADBEEF);
        chk("final_r10", d_rt_data, 32'hFFFFFFFE);
        d_rs_addr = 5'd31;
        d_rt_addr = 5'd7;
        #1;
        chk("final_r31", d_rs_data, 32'h0000300C);
        chk("final_r7", d_rt_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
